// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: byte-addressed data memory with little-endian byte
// lanes, alignment checking, load extension, and the MEM/WB pipeline register.
module mem_wb_stage #(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 8,
  parameter int NB_REG  = 5
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_valid,
  input  logic               i_stall,
  input  logic               i_flush,
  input  logic [NB_DATA-1:0] i_alu_result,
  input  logic [NB_DATA-1:0] i_store_data,
  input  logic               i_mem_read,
  input  logic               i_mem_write,
  input  logic [1:0]         i_size,
  input  logic               i_unsigned,
  input  logic               i_mem_to_reg,
  input  logic               i_reg_write,
  input  logic [NB_REG-1:0]  i_rd,
  output logic [NB_DATA-1:0] o_data_alu,
  output logic [NB_DATA-1:0] o_data_mem,
  output logic               o_selector,
  output logic               o_reg_write,
  output logic [NB_REG-1:0]  o_rd,
  output logic               o_valid,
  output logic               o_misaligned
);

  localparam int DEPTH = 1 << NB_ADDR;

  // Sign- or zero-extend a loaded byte to the datapath width.
  function automatic logic [NB_DATA-1:0] extend_byte(input logic signed [7:0] b,
                                                     input logic             uns);
    logic signed [NB_DATA-1:0] s;
    s = NB_DATA'(b);
    if (uns) return {{(NB_DATA-8){1'b0}}, b};
    else     return $unsigned(s);
  endfunction

  // Sign- or zero-extend a loaded halfword to the datapath width.
  function automatic logic [NB_DATA-1:0] extend_half(input logic signed [15:0] h,
                                                     input logic              uns);
    logic signed [NB_DATA-1:0] s;
    s = NB_DATA'(h);
    if (uns) return {{(NB_DATA-16){1'b0}}, h};
    else     return $unsigned(s);
  endfunction

  logic [NB_DATA-1:0] mem [DEPTH];

  // ---- MEM stage (p0): address decode, alignment, lane read/merge ----
  logic [NB_ADDR-1:0] word_addr_p0;
  logic [1:0]         byte_off_p0;
  logic               mis_raw_p0;
  logic               mis_p0;
  logic               mem_we_p0;
  logic [NB_DATA-1:0] rd_word_p0;
  logic [NB_DATA-1:0] wr_word_p0;
  logic [NB_DATA-1:0] load_p0;

  assign word_addr_p0 = i_alu_result[NB_ADDR+1:2];
  assign byte_off_p0  = i_alu_result[1:0];
  assign rd_word_p0   = mem[word_addr_p0];

  // Alignment check; reserved size 11 behaves as a word.
  always_comb begin
    mis_raw_p0 = 1'b0;
    case (i_size)
      2'b00:   mis_raw_p0 = 1'b0;
      2'b01:   mis_raw_p0 = byte_off_p0[0];
      default: mis_raw_p0 = |byte_off_p0;
    endcase
  end

  assign mis_p0    = i_valid & (i_mem_read | i_mem_write) & mis_raw_p0;
  assign mem_we_p0 = i_valid & i_mem_write & ~i_stall & ~i_flush & ~mis_p0 & ~i_rst;

  // Merge store data into the addressed lanes of the current word.
  always_comb begin
    wr_word_p0 = rd_word_p0;
    case (i_size)
      2'b00:   wr_word_p0[{byte_off_p0, 3'b000} +: 8]     = i_store_data[7:0];
      2'b01:   wr_word_p0[{byte_off_p0[1], 4'b0000} +: 16] = i_store_data[15:0];
      default: wr_word_p0 = i_store_data;
    endcase
  end

  // Extract and extend the addressed lane; zero when not a clean load.
  always_comb begin
    load_p0 = '0;
    if (i_mem_read && !mis_p0) begin
      case (i_size)
        2'b00:   load_p0 = extend_byte(rd_word_p0[{byte_off_p0, 3'b000} +: 8], i_unsigned);
        2'b01:   load_p0 = extend_half(rd_word_p0[{byte_off_p0[1], 4'b0000} +: 16], i_unsigned);
        default: load_p0 = rd_word_p0;
      endcase
    end
  end

  // Data memory write; contents are never reset.
  always_ff @(posedge i_clk) begin
    if (mem_we_p0) mem[word_addr_p0] <= wr_word_p0;
  end

  // ---- MEM/WB register (p1) ----
  logic [NB_DATA-1:0] data_alu_p1;
  logic [NB_DATA-1:0] data_mem_p1;
  logic               selector_p1;
  logic               reg_write_p1;
  logic [NB_REG-1:0]  rd_p1;
  logic               vld_p1;
  logic               mis_p1;

  // Capture on every unstalled edge; flush clears and beats stall.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst || i_flush) begin
      data_alu_p1  <= '0;
      data_mem_p1  <= '0;
      selector_p1  <= 1'b0;
      reg_write_p1 <= 1'b0;
      rd_p1        <= '0;
      vld_p1       <= 1'b0;
      mis_p1       <= 1'b0;
    end else if (!i_stall) begin
      data_alu_p1  <= i_alu_result;
      data_mem_p1  <= load_p0;
      selector_p1  <= i_mem_to_reg;
      reg_write_p1 <= i_reg_write & i_valid & ~mis_p0;
      rd_p1        <= i_rd;
      vld_p1       <= i_valid;
      mis_p1       <= mis_p0;
    end
  end

  assign o_data_alu   = data_alu_p1;
  assign o_data_mem   = data_mem_p1;
  assign o_selector   = selector_p1;
  assign o_reg_write  = reg_write_p1;
  assign o_rd         = rd_p1;
  assign o_valid      = vld_p1;
  assign o_misaligned = mis_p1;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed testbench for mem_wb_stage.
module tb_mem_wb_stage;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_valid = 1'b0;
  logic        i_stall = 1'b0;
  logic        i_flush = 1'b0;
  logic [31:0] i_alu_result = '0;
  logic [31:0] i_store_data = '0;
  logic        i_mem_read = 1'b0;
  logic        i_mem_write = 1'b0;
  logic [1:0]  i_size = 2'b00;
  logic        i_unsigned = 1'b0;
  logic        i_mem_to_reg = 1'b0;
  logic        i_reg_write = 1'b0;
  logic [4:0]  i_rd = '0;
  logic [31:0] o_data_alu;
  logic [31:0] o_data_mem;
  logic        o_selector;
  logic        o_reg_write;
  logic [4:0]  o_rd;
  logic        o_valid;
  logic        o_misaligned;

  int total = 0;
  int bad   = 0;

  mem_wb_stage #(.NB_DATA(32), .NB_ADDR(8), .NB_REG(5)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_stall(i_stall),
    .i_flush(i_flush), .i_alu_result(i_alu_result), .i_store_data(i_store_data),
    .i_mem_read(i_mem_read), .i_mem_write(i_mem_write), .i_size(i_size),
    .i_unsigned(i_unsigned), .i_mem_to_reg(i_mem_to_reg), .i_reg_write(i_reg_write),
    .i_rd(i_rd), .o_data_alu(o_data_alu), .o_data_mem(o_data_mem),
    .o_selector(o_selector), .o_reg_write(o_reg_write), .o_rd(o_rd),
    .o_valid(o_valid), .o_misaligned(o_misaligned)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic rd_en, input logic wr_en,
                       input logic [1:0] sz, input logic uns, input logic [31:0] addr,
                       input logic [31:0] sd, input logic m2r, input logic rw,
                       input logic [4:0] rdi);
    i_valid = v; i_mem_read = rd_en; i_mem_write = wr_en; i_size = sz;
    i_unsigned = uns; i_alu_result = addr; i_store_data = sd;
    i_mem_to_reg = m2r; i_reg_write = rw; i_rd = rdi;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0);
  endtask

  task automatic test_reset();
    #3;
    total++;
    if ({o_data_alu, o_data_mem, o_selector, o_reg_write, o_rd, o_valid, o_misaligned} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got alu=%h mem=%h sel=%b rw=%b rd=%0d v=%b mis=%b, need all 0",
               o_data_alu, o_data_mem, o_selector, o_reg_write, o_rd, o_valid, o_misaligned);
    end
    drive(1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hFFFF_FFFF, 1'b0, 1'b1, 5'd3);
    tick();
    total++;
    if (o_valid !== 1'b0 || o_data_alu !== 32'h0) begin
      bad++;
      $display("FAIL reset_hold_edge: got v=%b alu=%h, need 0/0", o_valid, o_data_alu);
    end
    idle();
    i_rst = 1'b0;
  endtask

  task automatic test_store_load();
    drive(1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 1'b0, 1'b0, 5'd0);
    tick();
    total++;
    if (o_valid !== 1'b1 || o_data_alu !== 32'h10 || o_data_mem !== 32'h0 || o_reg_write !== 1'b0) begin
      bad++;
      $display("FAIL sw_outputs: got v=%b alu=%h mem=%h rw=%b, need 1/00000010/0/0",
               o_valid, o_data_alu, o_data_mem, o_reg_write);
    end
    drive(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1, 1'b1, 5'd5);
    tick();
    total++;
    if (o_data_mem !== 32'hDEAD_BEEF || o_selector !== 1'b1 || o_reg_write !== 1'b1 || o_rd !== 5'd5) begin
      bad++;
      $display("FAIL lw_0x10: got mem=%h sel=%b rw=%b rd=%0d, need deadbeef/1/1/5",
               o_data_mem, o_selector, o_reg_write, o_rd);
    end
  endtask

  task automatic test_load_ext();
    drive(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 1'b1, 1'b1, 5'd6);
    tick();
    total++;
    if (o_data_mem !== 32'hFFFF_FFDE) begin
      bad++; $display("FAIL lb_0x13: got %h need ffffffde", o_data_mem);
    end
    drive(1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 1'b1, 1'b1, 5'd6);
    tick();
    total++;
    if (o_data_mem !== 32'h0000_00DE) begin
      bad++; $display("FAIL lbu_0x13: got %h need 000000de", o_data_mem);
    end
    drive(1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 1'b1, 1'b1, 5'd6);
    tick();
    total++;
    if (o_data_mem !== 32'hFFFF_DEAD) begin
      bad++; $display("FAIL lh_0x12: got %h need ffffdead", o_data_mem);
    end
    drive(1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 1'b1, 1'b1, 5'd6);
    tick();
    total++;
    if (o_data_mem !== 32'h0000_BEEF) begin
      bad++; $display("FAIL lhu_0x10: got %h need 0000beef", o_data_mem);
    end
    drive(1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 1'b1, 1'b1, 5'd6);
    tick();
    total++;
    if (o_data_mem !== 32'h0000_00BE) begin
      bad++; $display("FAIL lbu_0x11: got %h need 000000be", o_data_mem);
    end
  endtask

  task automatic test_byte_store_wrap();
    drive(1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 32'h11, 32'hAAAA_AA55, 1'b0, 1'b0, 5'd0);
    tick();
    drive(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1, 1'b1, 5'd7);
    tick();
    total++;
    if (o_data_mem !== 32'hDEAD_55EF) begin
      bad++; $display("FAIL sb_then_lw: got %h need dead55ef", o_data_mem);
    end
    drive(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h410, 32'h0, 1'b1, 1'b1, 5'd7);
    tick();
    total++;
    if (o_data_mem !== 32'hDEAD_55EF) begin
      bad++; $display("FAIL lw_wrap_0x410: got %h need dead55ef", o_data_mem);
    end
  endtask

  task automatic test_misaligned();
    drive(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h12, 32'h0, 1'b1, 1'b1, 5'd8);
    tick();
    total++;
    if (o_misaligned !== 1'b1 || o_reg_write !== 1'b0 || o_data_mem !== 32'h0) begin
      bad++;
      $display("FAIL lw_misaligned: got mis=%b rw=%b mem=%h, need 1/0/0", o_misaligned, o_reg_write, o_data_mem);
    end
    drive(1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 32'h11, 32'h0000_AAAA, 1'b0, 1'b1, 5'd8);
    tick();
    total++;
    if (o_misaligned !== 1'b1 || o_reg_write !== 1'b0) begin
      bad++; $display("FAIL sh_misaligned: got mis=%b rw=%b, need 1/0", o_misaligned, o_reg_write);
    end
    drive(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1, 1'b1, 5'd8);
    tick();
    total++;
    if (o_data_mem !== 32'hDEAD_55EF || o_misaligned !== 1'b0) begin
      bad++; $display("FAIL mem_unchanged_after_sh: got %h mis=%b need dead55ef/0", o_data_mem, o_misaligned);
    end
    drive(1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h12, 32'h0, 1'b1, 1'b1, 5'd8);
    tick();
    total++;
    if (o_misaligned !== 1'b0 || o_reg_write !== 1'b0 || o_valid !== 1'b0) begin
      bad++; $display("FAIL invalid_misaligned: got mis=%b rw=%b v=%b need 0/0/0", o_misaligned, o_reg_write, o_valid);
    end
  endtask

  task automatic test_stall_flush();
    drive(1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h20, 32'hCAFE_F00D, 1'b0, 1'b0, 5'd0);
    tick();
    drive(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1, 1'b1, 5'd7);
    tick();
    drive(1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h20, 32'h1234_5678, 1'b0, 1'b0, 5'd9);
    i_stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      total++;
      if (o_data_mem !== 32'hDEAD_55EF || o_data_alu !== 32'h10 || o_rd !== 5'd7 ||
          o_selector !== 1'b1 || o_reg_write !== 1'b1 || o_valid !== 1'b1) begin
        bad++;
        $display("FAIL stall_frozen[%0d]: got mem=%h alu=%h rd=%0d sel=%b rw=%b v=%b, need dead55ef/10/7/1/1/1",
                 c, o_data_mem, o_data_alu, o_rd, o_selector, o_reg_write, o_valid);
      end
    end
    i_flush = 1'b1;
    tick();
    total++;
    if ({o_data_alu, o_data_mem, o_selector, o_reg_write, o_rd, o_valid, o_misaligned} !== '0) begin
      bad++;
      $display("FAIL flush_over_stall: got alu=%h mem=%h rw=%b v=%b, need all 0",
               o_data_alu, o_data_mem, o_reg_write, o_valid);
    end
    i_flush = 1'b0;
    i_stall = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b1, 1'b1, 5'd10);
    tick();
    total++;
    if (o_data_mem !== 32'hCAFE_F00D) begin
      bad++; $display("FAIL lw_after_stall_flush: got %h need cafef00d", o_data_mem);
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h30, 32'h0BAD_CAFE, 1'b0, 1'b0, 5'd0);
    tick();
    drive(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 1'b1, 1'b1, 5'd11);
    tick();
    total++;
    if (o_data_mem !== 32'h0BAD_CAFE) begin
      bad++; $display("FAIL store_then_load: got %h need 0badcafe", o_data_mem);
    end
    drive(1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 32'h30, 32'h1111_1111, 1'b1, 1'b1, 5'd12);
    tick();
    total++;
    if (o_data_mem !== 32'h0BAD_CAFE) begin
      bad++; $display("FAIL read_write_prewrite: got %h need 0badcafe", o_data_mem);
    end
    drive(1'b1, 1'b1, 1'b0, 2'b11, 1'b0, 32'h30, 32'h0, 1'b1, 1'b1, 5'd12);
    tick();
    total++;
    if (o_data_mem !== 32'h1111_1111 || o_misaligned !== 1'b0) begin
      bad++; $display("FAIL reserved_size_word: got %h mis=%b need 11111111/0", o_data_mem, o_misaligned);
    end
    drive(1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 32'h32, 32'hFFFF_A5C3, 1'b0, 1'b0, 5'd0);
    tick();
    drive(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 1'b1, 1'b1, 5'd12);
    tick();
    total++;
    if (o_data_mem !== 32'hA5C3_1111) begin
      bad++; $display("FAIL sh_upper_lane: got %h need a5c31111", o_data_mem);
    end
  endtask

  task automatic test_async_reset();
    total++;
    if (o_valid !== 1'b1 || o_data_mem === 32'h0) begin
      bad++; $display("FAIL pre_reset_nonzero: got v=%b mem=%h, need v=1 mem!=0", o_valid, o_data_mem);
    end
    #1;
    i_rst = 1'b1;
    #1;
    total++;
    if ({o_data_alu, o_data_mem, o_selector, o_reg_write, o_rd, o_valid, o_misaligned} !== '0) begin
      bad++;
      $display("FAIL async_reset: got alu=%h mem=%h sel=%b rw=%b rd=%0d v=%b, need all 0",
               o_data_alu, o_data_mem, o_selector, o_reg_write, o_rd, o_valid);
    end
    drive(1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h30, 32'h9999_9999, 1'b0, 1'b0, 5'd0);
    tick();
    tick();
    idle();
    i_rst = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 1'b1, 1'b1, 5'd13);
    tick();
    total++;
    if (o_data_mem !== 32'hA5C3_1111 || o_rd !== 5'd13) begin
      bad++; $display("FAIL no_write_in_reset: got %h rd=%0d need a5c31111/13", o_data_mem, o_rd);
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_load_ext();
    test_byte_store_wrap();
    test_misaligned();
    test_stall_flush();
    test_back_to_back();
    test_async_reset();
    idle();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
